// File: rtl/weight_bram_sequencer_if.sv
// Handshake and BRAM-side bundle for weight_bram_sequencer.
// master = the sequencer, slave = producer/consumer/BRAM environment.
interface weight_bram_sequencer_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
);
  logic              START_WR;
  logic              START_RD;
  logic              WR_VALID;
  logic [DATA_W-1:0] WR_DATA;
  logic              WR_READY;
  logic              RD_VALID;
  logic [DATA_W-1:0] RD_DATA;
  logic              RD_LAST;
  logic              RD_READY;
  logic              BUSY;
  logic              DONE;
  logic [ADDR_W-1:0] BRAM_ADDR;
  logic [DATA_W-1:0] BRAM_DI;
  logic              BRAM_EN;
  logic              BRAM_WE;
  logic [DATA_W-1:0] BRAM_DO;

  modport master (
    input  START_WR, START_RD, WR_VALID, WR_DATA, RD_READY, BRAM_DO,
    output WR_READY, RD_VALID, RD_DATA, RD_LAST, BUSY, DONE,
           BRAM_ADDR, BRAM_DI, BRAM_EN, BRAM_WE
  );

  modport slave (
    output START_WR, START_RD, WR_VALID, WR_DATA, RD_READY, BRAM_DO,
    input  WR_READY, RD_VALID, RD_DATA, RD_LAST, BUSY, DONE,
           BRAM_ADDR, BRAM_DI, BRAM_EN, BRAM_WE
  );
endinterface

// File: rtl/weight_bram_sequencer.sv
// Weight BRAM controller: LOAD streams DEPTH words in, READ streams them out
// through a 2-entry FIFO with valid/ready backpressure.
module weight_bram_sequencer #(
  parameter int DEPTH  = 28,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
) (
  input logic CLK,
  input logic RST,
  weight_bram_sequencer_if.master bus
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, READ, FINISH} state_t;

  state_t state, state_n;

  logic [CNT_W-1:0]  wcnt, rcnt;
  logic [DATA_W-1:0] fifo_data [2];
  logic [1:0]        fifo_last;
  logic              rd_ptr, wr_ptr;
  logic [1:0]        count;
  logic              pend, pend_last;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] di_q;
  logic              en_q, we_q;

  logic       accept, pop, issue, rd_valid, rd_last;
  logic [2:0] occ_next;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  // Occupancy after this edge counts the read in flight, so issuing only
  // when it stays below 2 can never overflow the FIFO one cycle later.
  always_comb begin
    state_n  = state;
    rd_valid = (state == READ) && (count != 2'd0);
    rd_last  = rd_valid && fifo_last[rd_ptr];
    accept   = (state == LOAD) && bus.WR_VALID;
    pop      = rd_valid && bus.RD_READY;
    occ_next = {1'b0, count} + {2'b00, pend} - {2'b00, pop};
    issue    = (state == READ) && (rcnt < DEPTH_C) && (occ_next < 3'd2);
    case (state)
      IDLE: begin
        if (bus.START_WR)      state_n = LOAD;
        else if (bus.START_RD) state_n = READ;
      end
      LOAD:    if (accept && (wcnt == LAST_C)) state_n = FINISH;
      READ:    if (pop && rd_last)             state_n = FINISH;
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wcnt      <= '0;
      rcnt      <= '0;
      count     <= '0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      pend      <= 1'b0;
      pend_last <= 1'b0;
      fifo_last <= '0;
      for (int unsigned i = 0; i < 2; i++) fifo_data[i] <= '0;
      addr_q    <= '0;
      di_q      <= '0;
      en_q      <= 1'b0;
      we_q      <= 1'b0;
    end else begin
      en_q <= 1'b0;
      we_q <= 1'b0;
      pend <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.START_WR) begin
            wcnt <= '0;
          end else if (bus.START_RD) begin
            rcnt   <= '0;
            count  <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
          end
        end
        LOAD: begin
          if (accept) begin
            en_q   <= 1'b1;
            we_q   <= 1'b1;
            addr_q <= wcnt[ADDR_W-1:0];
            di_q   <= bus.WR_DATA;
            if (wcnt < DEPTH_C) wcnt <= wcnt + 1'b1;
          end
        end
        READ: begin
          pend <= issue;
          if (issue) begin
            en_q      <= 1'b1;
            addr_q    <= rcnt[ADDR_W-1:0];
            pend_last <= (rcnt == LAST_C);
            rcnt      <= rcnt + 1'b1;
          end
          if (pend) begin
            fifo_data[wr_ptr] <= bus.BRAM_DO;
            fifo_last[wr_ptr] <= pend_last;
            wr_ptr            <= ~wr_ptr;
          end
          if (pop) rd_ptr <= ~rd_ptr;
          count <= occ_next[1:0];
        end
        FINISH: begin
          count  <= '0;
          rd_ptr <= 1'b0;
          wr_ptr <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.WR_READY  = (state == LOAD);
  assign bus.RD_VALID  = rd_valid;
  assign bus.RD_DATA   = fifo_data[rd_ptr];
  assign bus.RD_LAST   = rd_last;
  assign bus.BUSY      = (state != IDLE);
  assign bus.DONE      = (state == FINISH);
  assign bus.BRAM_ADDR = addr_q;
  assign bus.BRAM_DI   = di_q;
  assign bus.BRAM_EN   = en_q;
  assign bus.BRAM_WE   = we_q;

endmodule

// File: tb/tb_weight_bram_sequencer.sv
// Randomized self-checking bench for weight_bram_sequencer with a negedge
// BRAM model and a word-level reference of the expected BRAM contents.
module tb_weight_bram_sequencer;
  localparam int DEPTH  = 28;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 16;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  weight_bram_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  weight_bram_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  logic [DATA_W-1:0] bram [1 << ADDR_W];
  always @(negedge CLK) begin
    if (bus.BRAM_EN) begin
      if (bus.BRAM_WE) bram[bus.BRAM_ADDR] <= bus.BRAM_DI;
      else             bus.BRAM_DO <= bram[bus.BRAM_ADDR];
    end
  end

  logic [DATA_W-1:0] ref_mem [DEPTH];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // vmode: 0 always valid, 1 valid low every 3rd cycle, 2 random valid + random START_RD
  // dmode: 0 -> 0x0100+i, 1 -> i*3, 2 -> random
  task automatic load_job(input int vmode, input int dmode, input bit both);
    int n = 0;
    int c = 0;
    int dones = 0;
    bit v, acc;
    logic [DATA_W-1:0] d;
    bus.START_WR = 1'b1;
    bus.START_RD = both;
    tick();
    bus.START_WR = 1'b0;
    bus.START_RD = 1'b0;
    check("load_busy", bus.BUSY, 1);
    while (n < DEPTH && c < 300) begin
      v = (vmode == 0) ? 1'b1 : (vmode == 1) ? (c % 3 != 2) : ($urandom_range(0, 3) != 0);
      d = (dmode == 0) ? DATA_W'(16'h0100 + n) : (dmode == 1) ? DATA_W'(n * 3) : DATA_W'($urandom);
      bus.WR_VALID = v;
      bus.WR_DATA  = d;
      if (vmode == 2) bus.START_RD = ($urandom_range(0, 4) == 0);
      check("load_ready", bus.WR_READY, 1);
      acc = v;
      if (acc) ref_mem[n] = d;
      tick();
      check("load_we", bus.BRAM_WE, acc);
      check("load_en", bus.BRAM_EN, acc);
      if (acc) begin
        check("load_addr", bus.BRAM_ADDR, n);
        check("load_di", bus.BRAM_DI, d);
        n++;
      end
      check("load_done", bus.DONE, acc && n == DEPTH);
      if (bus.DONE) dones++;
      c++;
    end
    check("load_words", n, DEPTH);
    bus.WR_VALID = 1'b0;
    bus.START_RD = 1'b0;
    tick();
    check("load_idle_busy", bus.BUSY, 0);
    check("load_idle_done", bus.DONE, 0);
    check("load_idle_ready", bus.WR_READY, 0);
    check("load_idle_en", bus.BRAM_EN, 0);
    for (int k = 0; k < 4; k++) begin
      bus.WR_VALID = 1'b1;
      bus.WR_DATA  = DATA_W'($urandom);
      tick();
      check("idle_busy", bus.BUSY, 0);
      check("idle_en", bus.BRAM_EN, 0);
      check("idle_rdvalid", bus.RD_VALID, 0);
      if (bus.DONE) dones++;
    end
    bus.WR_VALID = 1'b0;
    check("load_done_once", dones, 1);
    for (int i = 0; i < DEPTH; i++) check("bram_contents", bram[i], ref_mem[i]);
  endtask

  // rmode: 0 ready always, 1 ready 1,0,0,1 repeating, 2 random; abort_after>0 resets after that many words
  task automatic read_job(input int rmode, input int abort_after);
    int j = 0;
    int issued = 0;
    int c = 0;
    int first = -1;
    bit r, v, l, hs, prev_stall, fin;
    logic [DATA_W-1:0] d, prev_d;
    prev_stall = 1'b0;
    prev_d     = '0;
    fin        = 1'b0;
    bus.START_RD = 1'b1;
    tick();
    bus.START_RD = 1'b0;
    check("rd_busy", bus.BUSY, 1);
    while (!fin && c < 400) begin
      r = (rmode == 0) ? 1'b1 : (rmode == 1) ? (c % 4 == 0 || c % 4 == 3) : 1'($urandom_range(0, 1));
      bus.RD_READY = r;
      v = bus.RD_VALID;
      d = bus.RD_DATA;
      l = bus.RD_LAST;
      if (prev_stall) begin
        check("rd_hold_valid", v, 1);
        check("rd_hold_data", d, prev_d);
      end
      if (v && first < 0) first = c;
      if (rmode == 0 && first >= 0) check("rd_fullrate", v, 1);
      if (v) check("rd_last", l, (j == DEPTH - 1));
      hs = v && r;
      if (hs) begin
        check("rd_data", d, ref_mem[j]);
        j++;
      end
      prev_stall = v && !r;
      prev_d     = d;
      tick();
      c++;
      check("rd_done", bus.DONE, hs && j == DEPTH);
      if (bus.BRAM_EN) begin
        check("rd_we", bus.BRAM_WE, 0);
        check("rd_addr", bus.BRAM_ADDR, issued);
        issued++;
      end
      check("rd_outstanding", (issued - j) <= 2, 1);
      if (hs && j == DEPTH) fin = 1'b1;
      if (abort_after > 0 && j == abort_after) begin
        RST = 1'b1;
        tick();
        RST = 1'b0;
        bus.RD_READY = 1'b0;
        check("abort_rdvalid", bus.RD_VALID, 0);
        check("abort_busy", bus.BUSY, 0);
        check("abort_done", bus.DONE, 0);
        tick();
        check("abort_done2", bus.DONE, 0);
        return;
      end
    end
    check("rd_words", j, DEPTH);
    if (rmode == 0) check("rd_latency", first, 2);
    bus.RD_READY = 1'b0;
    tick();
    check("rd_idle_busy", bus.BUSY, 0);
    check("rd_idle_done", bus.DONE, 0);
    check("rd_idle_en", bus.BRAM_EN, 0);
  endtask

  initial begin
    RST          = 1'b1;
    bus.START_WR = 1'b0;
    bus.START_RD = 1'b0;
    bus.WR_VALID = 1'b0;
    bus.WR_DATA  = '0;
    bus.RD_READY = 1'b0;
    tick();
    tick();
    check("rst_wr_ready", bus.WR_READY, 0);
    check("rst_rd_valid", bus.RD_VALID, 0);
    check("rst_rd_last", bus.RD_LAST, 0);
    check("rst_rd_data", bus.RD_DATA, 0);
    check("rst_busy", bus.BUSY, 0);
    check("rst_done", bus.DONE, 0);
    check("rst_en", bus.BRAM_EN, 0);
    check("rst_we", bus.BRAM_WE, 0);
    check("rst_addr", bus.BRAM_ADDR, 0);
    check("rst_di", bus.BRAM_DI, 0);
    RST = 1'b0;
    tick();

    load_job(0, 0, 1'b0);
    load_job(1, 0, 1'b0);
    load_job(0, 2, 1'b1);
    load_job(0, 1, 1'b0);
    read_job(0, 0);
    read_job(1, 0);
    read_job(0, 10);
    read_job(0, 0);
    for (int it = 0; it < 3; it++) begin
      load_job(2, 2, 1'b0);
      read_job(2, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
